edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_pkg.sv | 18 +
 rtl/edge_event_ch.sv | 77 +++++++
 rtl/edge_event_arbiter.sv | 91 +++++++++
 tb/tb_edge_event_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared constants and encodings for the edge event arbiter.
package edge_pkg;

  localparam int unsigned NumChDefault = 4;

  // Channel-index width, never below one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : unsigned'($clog2(n));
  endfunction

  localparam int unsigned ChWDefault = ch_width(NumChDefault);

  typedef enum logic {
    EvtRise = 1'b0,
    EvtFall = 1'b1
  } evt_type_e;

endpackage

// File: rtl/edge_event_ch.sv
// One monitored line: edge detect, rise/fall pending bits with age order, sticky overflow.
module edge_event_ch
  import edge_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      a_i,
  input  logic      clr_ovf_i,
  input  logic      take_i,
  output logic      req_o,
  output evt_type_e req_type_o,
  output logic      ovf_o
);

  logic a_q, armed_q, rise_q, fall_q, order_q, ovf_q;
  logic rise_edge, fall_edge, rise_vis, fall_vis, fall_older;
  logic clr_rise, clr_fall;
  logic rise_old_kept, fall_old_kept, rise_new_kept, fall_new_kept;
  logic rise_d, fall_d, order_d, ovf_d, ovf_hit;

  always_comb begin
    rise_edge  = armed_q & ~a_q & a_i;
    fall_edge  = armed_q & a_q & ~a_i;
    // A fresh edge is visible to the arbiter in the cycle it is detected.
    rise_vis   = rise_q | rise_edge;
    fall_vis   = fall_q | fall_edge;
    fall_older = (rise_q & fall_q) ? order_q : fall_q;
    req_o      = rise_vis | fall_vis;
    req_type_o = (fall_vis & (~rise_vis | fall_older)) ? EvtFall : EvtRise;

    clr_rise = take_i & (req_type_o == EvtRise);
    clr_fall = take_i & (req_type_o == EvtFall);

    rise_old_kept = rise_q & ~clr_rise;
    fall_old_kept = fall_q & ~clr_fall;
    // A new edge survives if its slot is free, or freed by this cycle's take.
    rise_new_kept = rise_edge & (rise_q ~^ clr_rise);
    fall_new_kept = fall_edge & (fall_q ~^ clr_fall);
    ovf_hit       = (rise_edge & rise_q & ~clr_rise) | (fall_edge & fall_q & ~clr_fall);

    rise_d = rise_old_kept | rise_new_kept;
    fall_d = fall_old_kept | fall_new_kept;

    // order_q set means the pending fall is older than the pending rise.
    if (rise_old_kept & fall_old_kept) begin
      order_d = order_q;
    end else if (fall_old_kept) begin
      order_d = 1'b1;
    end else if (rise_old_kept) begin
      order_d = 1'b0;
    end else begin
      order_d = fall_new_kept;
    end

    ovf_d = (ovf_q & ~clr_ovf_i) | ovf_hit;
    ovf_o = ovf_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      order_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_i;
      armed_q <= 1'b1;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      order_q <= order_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter over per-channel edge events, feeding a registered valid/ready slot.
module edge_event_arbiter
  import edge_pkg::*;
#(
  parameter int unsigned NUM_CH = NumChDefault,
  parameter int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] a_in,
  input  logic              clr_ovf,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_fall,
  output logic [NUM_CH-1:0] ovf
);

  logic [NUM_CH-1:0] req, take;
  evt_type_e         req_type [NUM_CH];

  logic            valid_q, valid_d, fall_q, fall_d, load, found;
  logic [CH_W-1:0] ch_q, ch_d, ptr_q, ptr_d, sel, cand;
  int unsigned     idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_event_ch u_ch (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .a_i        (a_in[g]),
      .clr_ovf_i  (clr_ovf),
      .take_i     (take[g]),
      .req_o      (req[g]),
      .req_type_o (req_type[g]),
      .ovf_o      (ovf[g])
    );
  end

  always_comb begin
    load    = ~valid_q | evt_ready;
    found   = 1'b0;
    sel     = '0;
    cand    = '0;
    idx     = 0;
    take    = '0;
    valid_d = valid_q;
    ch_d    = ch_q;
    fall_d  = fall_q;
    ptr_d   = ptr_q;

    // Search starts just after the last granted channel and wraps.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(ptr_q) + i + 32'd1;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = idx[CH_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    if (load) begin
      valid_d = found;
      if (found) begin
        ch_d      = sel;
        fall_d    = (req_type[sel] == EvtFall);
        ptr_d     = sel;
        take[sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      fall_q  <= 1'b0;
      ptr_q   <= CH_W'(NUM_CH - 1);
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      fall_q  <= fall_d;
      ptr_q   <= ptr_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_ch    = ch_q;
  assign evt_fall  = fall_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: expected events queued at stimulus, checked on handshake.
module tb_edge_event_arbiter;

  localparam int unsigned NCh = 4;
  localparam int unsigned ChW = 2;

  logic           clk = 1'b0;
  logic           reset_n, clr_ovf, evt_valid, evt_ready, evt_fall;
  logic [NCh-1:0] a_in, ovf;
  logic [ChW-1:0] evt_ch;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  edge_event_arbiter #(
    .NUM_CH (NCh),
    .CH_W   (ChW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_in      (a_in),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_fall  (evt_fall),
    .ovf       (ovf)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Event code: ch*2 + fall.
  function automatic int evt_code();
    return int'(evt_ch) * 2 + int'(evt_fall);
  endfunction

  // Scores a handshake about to complete, then advances to 1 time unit after the next edge.
  task automatic tick();
    if (evt_valid && evt_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_evt", evt_code(), -1);
      else                   check_eq("sb_evt", evt_code(), exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int budget = 30;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    a_in      = '0;
    clr_ovf   = 1'b0;
    evt_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", int'(evt_valid), 0);
    check_eq("rst_ch", int'(evt_ch), 0);
    check_eq("rst_fall", int'(evt_fall), 0);
    check_eq("rst_ovf", int'(ovf), 0);
    reset_n = 1'b1;
    repeat (2) tick();
    check_eq("idle_valid", int'(evt_valid), 0);

    // Simultaneous rises, then simultaneous falls: both bursts start at ch0.
    a_in = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i * 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("burst1_valid", int'(evt_valid), 1);
      check_eq("burst1_ch", int'(evt_ch), i);
    end
    tick();
    check_eq("burst1_end", int'(evt_valid), 0);
    drain("burst1_drain");

    a_in = 4'b0000;
    for (int i = 0; i < 4; i++) exp_q.push_back(i * 2 + 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("burst2_ch", int'(evt_ch), i);
      check_eq("burst2_fall", int'(evt_fall), 1);
    end
    drain("burst2_drain");

    // Single rise on ch1: presented exactly one cycle after detection, for one cycle.
    a_in[1] = 1'b1;
    exp_q.push_back(2);
    check_eq("lat_before", int'(evt_valid), 0);
    tick();
    check_eq("lat_valid", int'(evt_valid), 1);
    check_eq("lat_ch", int'(evt_ch), 1);
    check_eq("lat_fall", int'(evt_fall), 0);
    tick();
    check_eq("lat_one_cycle", int'(evt_valid), 0);
    drain("lat_drain");
    a_in[1] = 1'b0;
    exp_q.push_back(3);
    drain("ch1_fall_drain");

    // Stall with ch3 presented; ch2 rise/fall pending, second rise overflows.
    evt_ready = 1'b0;
    a_in[3]   = 1'b1;
    exp_q.push_back(6);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin a_in[2] = 1'b1; exp_q.push_back(4); end
      if (i == 1) begin a_in[2] = 1'b0; exp_q.push_back(5); end
      if (i == 2) a_in[2] = 1'b1;
      check_eq("hold_valid", int'(evt_valid), 1);
      check_eq("hold_ch", int'(evt_ch), 3);
      check_eq("hold_fall", int'(evt_fall), 0);
      tick();
    end
    check_eq("ovf_ch2", int'(ovf), 4);
    evt_ready = 1'b1;
    drain("ovf_drain");
    check_eq("ovf_sticky", int'(ovf), 4);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("ovf_cleared", int'(ovf), 0);

    // Overflow coinciding with clr_ovf keeps the bit.
    evt_ready = 1'b0;
    a_in[0]   = 1'b1;
    exp_q.push_back(0);
    tick();
    a_in[1] = 1'b1;
    exp_q.push_back(2);
    tick();
    a_in[1] = 1'b0;
    exp_q.push_back(3);
    tick();
    a_in[1] = 1'b1;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("ovf_wins_clr", int'(ovf), 2);
    evt_ready = 1'b1;
    drain("ovf2_drain");
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("ovf2_cleared", int'(ovf), 0);

    // Reset mid-operation with an event presented and three pending; lines held high.
    evt_ready = 1'b0;
    a_in      = 4'b0000;
    tick();
    check_eq("pre_rst_valid", int'(evt_valid), 1);
    reset_n = 1'b0;
    a_in    = 4'b1111;
    #1;
    check_eq("async_rst_valid", int'(evt_valid), 0);
    check_eq("async_rst_ch", int'(evt_ch), 0);
    repeat (2) tick();
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("no_stale", int'(evt_valid), 0);
    end
    a_in[0] = 1'b0;
    exp_q.push_back(1);
    tick();
    check_eq("post_rst_valid", int'(evt_valid), 1);
    check_eq("post_rst_ch", int'(evt_ch), 0);
    check_eq("post_rst_fall", int'(evt_fall), 1);
    drain("post_rst_drain");
    tick();
    check_eq("final_idle", int'(evt_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
